udma_evt_collector: RTL

//  Downstream consumer of the uDMA subsystem event vector (events_o, N_PERIPHS x N_EVT single-cycle pulses).

---
 rtl/udma_evt_collector.sv | 90 +++++++++
 1 files changed

// File: rtl/udma_evt_collector.sv
// udma_evt_collector: buffers uDMA event pulses in per-line saturating counters and serialises them round-robin (optional line mask via UDMA_EVT_MASK_EN)
module udma_evt_collector #(
  parameter int N_PERIPHS = 32,
  parameter int N_EVT = 4,
  parameter int CNT_WIDTH = 2,
  localparam int N = N_PERIPHS * N_EVT,
  localparam int ID_WIDTH = $clog2(N)
) (
  input  logic                             sys_clk_i,
  input  logic                             sys_reset_i,
  input  logic [N_PERIPHS-1:0][N_EVT-1:0]  events_i,
`ifdef UDMA_EVT_MASK_EN
  input  logic [N-1:0]                     evt_mask_i,
`endif
  output logic                             evt_valid_o,
  output logic [ID_WIDTH-1:0]              evt_id_o,
  input  logic                             evt_ready_i,
  input  logic                             ovf_clr_i,
  output logic                             overflow_o,
  output logic [ID_WIDTH-1:0]              ovf_id_o,
  output logic                             pending_o
);
  localparam logic [CNT_WIDTH-1:0] MAX = '1;
  logic [CNT_WIDTH-1:0] cnt [N];
  logic [N-1:0] nz, inc, grant, drop;
  logic [ID_WIDTH-1:0] rr_ptr, sel, sel_lo, sel_hi, drop_id;
  logic has_hi, load;
`ifdef UDMA_EVT_MASK_EN
  assign inc = events_i & ~evt_mask_i;
`else
  assign inc = events_i;
`endif
  assign pending_o = |nz;
  assign load = (!evt_valid_o || evt_ready_i) && pending_o;
  // round-robin pick: lowest busy line above rr_ptr, else lowest busy line overall
  always_comb begin
    nz = '0;
    sel_lo = '0;
    sel_hi = '0;
    has_hi = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      nz[i] = cnt[i] != '0;
      if (nz[i]) sel_lo = ID_WIDTH'(i);
      if (nz[i] && ID_WIDTH'(i) > rr_ptr) begin
        sel_hi = ID_WIDTH'(i);
        has_hi = 1'b1;
      end
    end
    sel = has_hi ? sel_hi : sel_lo;
  end
  // grant vector and saturation drops, lowest dropped line reported
  always_comb begin
    grant = '0;
    grant[sel] = load;
    drop = '0;
    drop_id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      drop[i] = inc[i] && !grant[i] && cnt[i] == MAX;
      if (drop[i]) drop_id = ID_WIDTH'(i);
    end
  end
  // per-line pending counters: simultaneous inc and grant cancel out
  always_ff @(posedge sys_clk_i)
    for (int i = 0; i < N; i++)
      if (sys_reset_i) cnt[i] <= '0;
      else if (inc[i] != grant[i]) cnt[i] <= inc[i] ? (cnt[i] == MAX ? cnt[i] : cnt[i] + 1'b1) : cnt[i] - 1'b1;
  // single in-flight output slot, refilled whenever it is free or being consumed
  always_ff @(posedge sys_clk_i)
    if (sys_reset_i) begin
      evt_valid_o <= 1'b0;
      evt_id_o <= '0;
      rr_ptr <= ID_WIDTH'(N - 1);
    end else if (load) begin
      evt_valid_o <= 1'b1;
      evt_id_o <= sel;
      rr_ptr <= sel;
    end else if (evt_ready_i) evt_valid_o <= 1'b0;
  // sticky overflow: clear takes effect first so a same-cycle drop is still captured
  always_ff @(posedge sys_clk_i)
    if (sys_reset_i) begin
      overflow_o <= 1'b0;
      ovf_id_o <= '0;
    end else if (|drop && (ovf_clr_i || !overflow_o)) begin
      overflow_o <= 1'b1;
      ovf_id_o <= drop_id;
    end else if (ovf_clr_i) begin
      overflow_o <= 1'b0;
      ovf_id_o <= '0;
    end
endmodule
